// File: rtl/ula_seq.sv
// ula_seq: valid/ready sequencing controller around a 32-bit ULA.
// Single-step ops (AND/OR/ADD/AND-NOT-B/OR-NOT-B/SUB/SLT) take one ULA cycle.
// Opcode 011 is a 32-iteration shift-and-add multiply (low 32 bits) on the same ULA.
// Build option: ULA_SEQ_MUL_EN enables the multiply. Without it, opcode 011
// returns y=0, zero=1, err=1 after one cycle.
module ula_seq (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_a,
   input  logic [31:0] in_b,
   input  logic [2:0]  in_op,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_y,
   output logic        out_zero,
   output logic        out_err,
   output logic        busy
);

   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_MUL = 3'b011;

   typedef enum logic [1:0] {
      S_IDLE,
      S_EXEC,
`ifdef ULA_SEQ_MUL_EN
      S_MUL,
`endif
      S_DONE
   } state_t;

   state_t      state, state_n;

   logic [31:0] a_q, b_q;
   logic [2:0]  op_q;
   logic [31:0] y_q;
   logic        zero_q, err_q;

   logic [2:0]  ula_f;
   logic [31:0] ula_a, ula_b, ula_bb, ula_sum, ula_y;

`ifdef ULA_SEQ_MUL_EN
   logic [31:0] acc, mcand, mplr, acc_n;
   logic [4:0]  cnt;
`endif

   // ULA: f[2] inverts B and injects carry-in, f[1:0] selects AND/OR/SUM/SLT
   always_comb begin
      ula_bb  = ula_f[2] ? ~ula_b : ula_b;
      ula_sum = ula_a + ula_bb + {31'b0, ula_f[2]};
      case (ula_f[1:0])
         2'b00:   ula_y = ula_a & ula_bb;
         2'b01:   ula_y = ula_a | ula_bb;
         2'b10:   ula_y = ula_sum;
         default: ula_y = {31'b0, ula_sum[31]};
      endcase
   end

   // ULA operand/function select: captured request in EXEC, accumulate step in MUL
   always_comb begin
      ula_a = a_q;
      ula_b = b_q;
      ula_f = op_q;
`ifdef ULA_SEQ_MUL_EN
      if (state == S_MUL) begin
         ula_a = acc;
         ula_b = mcand;
         ula_f = OP_ADD;
      end
      acc_n = mplr[0] ? ula_y : acc;
`endif
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_n;
   end

   // Next-state and handshake outputs
   always_comb begin
      state_n   = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b1;
      case (state)
         S_IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid) begin
`ifdef ULA_SEQ_MUL_EN
               state_n = (in_op == OP_MUL) ? S_MUL : S_EXEC;
`else
               state_n = S_EXEC;
`endif
            end
         end
         S_EXEC: state_n = S_DONE;
`ifdef ULA_SEQ_MUL_EN
         S_MUL: if (cnt == 5'd31) state_n = S_DONE;
`endif
         S_DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_n = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
   end

   // Datapath: request capture, single-step result, multiply iterations
   always_ff @(posedge clk) begin
      if (reset) begin
         a_q    <= '0;
         b_q    <= '0;
         op_q   <= '0;
         y_q    <= '0;
         zero_q <= 1'b0;
         err_q  <= 1'b0;
`ifdef ULA_SEQ_MUL_EN
         acc    <= '0;
         mcand  <= '0;
         mplr   <= '0;
         cnt    <= '0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  a_q   <= in_a;
                  b_q   <= in_b;
                  op_q  <= in_op;
`ifdef ULA_SEQ_MUL_EN
                  acc   <= '0;
                  mcand <= in_a;
                  mplr  <= in_b;
                  cnt   <= '0;
`endif
               end
            end
            S_EXEC: begin
`ifndef ULA_SEQ_MUL_EN
               if (op_q == OP_MUL) begin
                  y_q    <= '0;
                  zero_q <= 1'b1;
                  err_q  <= 1'b1;
               end else
`endif
               begin
                  y_q    <= ula_y;
                  zero_q <= (ula_y == '0);
                  err_q  <= 1'b0;
               end
            end
`ifdef ULA_SEQ_MUL_EN
            S_MUL: begin
               acc   <= acc_n;
               mcand <= mcand << 1;
               mplr  <= mplr >> 1;
               cnt   <= cnt + 5'd1;
               // last iteration lands straight in the result register
               if (cnt == 5'd31) begin
                  y_q    <= acc_n;
                  zero_q <= (acc_n == '0);
                  err_q  <= 1'b0;
               end
            end
`endif
            default: ;
         endcase
      end
   end

   assign out_y    = y_q;
   assign out_zero = zero_q;
   assign out_err  = err_q;

endmodule

// File: tb/tb_ula_seq.sv
// Testbench for ula_seq: randomized and directed requests against a plain
// arithmetic reference model; honours ULA_SEQ_MUL_EN the same way as the design.
module tb_ula_seq;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_a = '0;
   logic [31:0] in_b = '0;
   logic [2:0]  in_op = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_y;
   logic        out_zero;
   logic        out_err;
   logic        busy;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int acc_cyc = 0;

   logic [31:0] r_y;
   logic        r_zero, r_err;
   int          r_lat;

   ula_seq dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_op(in_op),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_y(out_y), .out_zero(out_zero), .out_err(out_err),
      .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference: returns {err, y}
   function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] op);
      logic [31:0] d;
      d = a - b;
      case (op)
         3'b000: return {1'b0, a & b};
         3'b001: return {1'b0, a | b};
         3'b010: return {1'b0, a + b};
         3'b100: return {1'b0, a & ~b};
         3'b101: return {1'b0, a | ~b};
         3'b110: return {1'b0, d};
         3'b111: return {1'b0, 31'b0, d[31]};
`ifdef ULA_SEQ_MUL_EN
         default: return {1'b0, a * b};
`else
         default: return {1'b1, 32'b0};
`endif
      endcase
   endfunction

   function automatic int model_lat(input logic [2:0] op);
`ifdef ULA_SEQ_MUL_EN
      return (op == 3'b011) ? 32 : 1;
`else
      return 1;
`endif
   endfunction

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 5))
         0: return 32'h0000_0000;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   // Present a request and wait until it is accepted; operands are scrambled afterwards
   task automatic accept_req(input logic [31:0] a, input logic [31:0] b,
                             input logic [2:0] op, input bit early);
      int n;
      @(negedge clk);
      n = 0;
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         checks++;
         failures++;
         $display("FAIL accept_wait in_ready=%b required=1", in_ready);
      end
      in_valid  = 1'b1;
      in_a      = a;
      in_b      = b;
      in_op     = op;
      out_ready = early;
      @(posedge clk);
      #1;
      acc_cyc  = cyc;
      in_valid = 1'b0;
      in_a     = $urandom;
      in_b     = $urandom;
      in_op    = 3'($urandom);
   endtask

   // Accept a request and wait (bounded) for out_valid; leaves the response pending
   task automatic start_txn(input logic [31:0] a, input logic [31:0] b,
                            input logic [2:0] op, input bit early);
      accept_req(a, b, op, early);
      r_lat = 0;
      do begin
         @(posedge clk);
         #1;
         r_lat++;
      end while (!out_valid && r_lat < 100);
      if (!out_valid) begin
         checks++;
         failures++;
         $display("FAIL result_wait out_valid=%b required=1", out_valid);
      end
      r_y    = out_y;
      r_zero = out_zero;
      r_err  = out_err;
   endtask

   task automatic finish_txn();
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      checks++; if (out_y !== 32'h0) begin failures++; $display("FAIL reset_y got=%h required=0", out_y); end
      checks++; if (out_zero !== 1'b0) begin failures++; $display("FAIL reset_zero got=%b required=0", out_zero); end
      checks++; if (out_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b required=0", out_err); end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b required=0", out_valid); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b required=0", busy); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b required=1", in_ready); end
   endtask

   task automatic test_directed();
      logic [31:0] a_t[4] = '{32'h5, 32'h7, 32'hFFFF_FFFF, 32'hF0F0_F0F0};
      logic [31:0] b_t[4] = '{32'h3, 32'h7, 32'h1, 32'h0FF0_0FF0};
      logic [2:0]  o_t[4] = '{3'b010, 3'b110, 3'b111, 3'b000};
      logic [31:0] y_t[4] = '{32'h8, 32'h0, 32'h1, 32'h00F0_00F0};
      for (int i = 0; i < 4; i++) begin
         start_txn(a_t[i], b_t[i], o_t[i], 1'b1);
         checks++; if (r_lat != 1) begin failures++; $display("FAIL dir%0d_latency got=%0d required=1", i, r_lat); end
         checks++; if (r_y !== y_t[i]) begin failures++; $display("FAIL dir%0d_y got=%h required=%h", i, r_y, y_t[i]); end
         checks++; if (r_zero !== (y_t[i] == 0)) begin failures++; $display("FAIL dir%0d_zero got=%b required=%b", i, r_zero, y_t[i] == 0); end
         checks++; if (r_err !== 1'b0) begin failures++; $display("FAIL dir%0d_err got=%b required=0", i, r_err); end
         finish_txn();
         checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL dir%0d_ready_after got=%b required=1", i, in_ready); end
         checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL dir%0d_no_dup got=%b required=0", i, out_valid); end
      end
   endtask

   task automatic test_random();
      logic [31:0] a, b;
      logic [2:0]  op;
      logic [32:0] exp;
      int          hold;
      for (int i = 0; i < 40; i++) begin
         a    = pick_operand();
         b    = pick_operand();
         op   = 3'($urandom_range(0, 7));
         hold = $urandom_range(0, 3);
         exp  = model(a, b, op);
         start_txn(a, b, op, (hold == 0));
         if (hold != 0) begin
            repeat (hold) @(posedge clk);
            #1;
         end
         checks++; if (r_lat != model_lat(op)) begin failures++; $display("FAIL rnd%0d_latency op=%b got=%0d required=%0d", i, op, r_lat, model_lat(op)); end
         checks++; if (out_y !== exp[31:0]) begin failures++; $display("FAIL rnd%0d_y op=%b a=%h b=%h got=%h required=%h", i, op, a, b, out_y, exp[31:0]); end
         checks++; if (out_zero !== (exp[31:0] == 0)) begin failures++; $display("FAIL rnd%0d_zero got=%b required=%b", i, out_zero, exp[31:0] == 0); end
         checks++; if (out_err !== exp[32]) begin failures++; $display("FAIL rnd%0d_err got=%b required=%b", i, out_err, exp[32]); end
         finish_txn();
      end
   endtask

`ifdef ULA_SEQ_MUL_EN
   task automatic test_mul();
      logic [31:0] a_t[3] = '{32'h0000_1234, 32'hFFFF_FFFF, 32'h0};
      logic [31:0] b_t[3] = '{32'h0000_5678, 32'hFFFF_FFFF, 32'h1234_5678};
      logic [31:0] y_t[3] = '{32'h0626_0060, 32'h0000_0001, 32'h0};
      for (int i = 0; i < 3; i++) begin
         start_txn(a_t[i], b_t[i], 3'b011, 1'b0);
         checks++; if (r_lat != 32) begin failures++; $display("FAIL mul%0d_latency got=%0d required=32", i, r_lat); end
         checks++; if (r_y !== y_t[i]) begin failures++; $display("FAIL mul%0d_y got=%h required=%h", i, r_y, y_t[i]); end
         checks++; if (r_zero !== (y_t[i] == 0)) begin failures++; $display("FAIL mul%0d_zero got=%b required=%b", i, r_zero, y_t[i] == 0); end
         checks++; if (r_err !== 1'b0) begin failures++; $display("FAIL mul%0d_err got=%b required=0", i, r_err); end
         finish_txn();
      end
   endtask
`else
   task automatic test_unsupported();
      start_txn(32'd3, 32'd4, 3'b011, 1'b0);
      checks++; if (r_lat != 1) begin failures++; $display("FAIL unsup_latency got=%0d required=1", r_lat); end
      checks++; if (r_y !== 32'h0) begin failures++; $display("FAIL unsup_y got=%h required=0", r_y); end
      checks++; if (r_zero !== 1'b1) begin failures++; $display("FAIL unsup_zero got=%b required=1", r_zero); end
      checks++; if (r_err !== 1'b1) begin failures++; $display("FAIL unsup_err got=%b required=1", r_err); end
      finish_txn();
      start_txn(32'h1, 32'h2, 3'b001, 1'b0);
      checks++; if (r_y !== 32'h3) begin failures++; $display("FAIL unsup_or_y got=%h required=3", r_y); end
      checks++; if (r_err !== 1'b0) begin failures++; $display("FAIL unsup_or_err got=%b required=0", r_err); end
      finish_txn();
   endtask
`endif

   task automatic test_backpressure();
      logic [31:0] a, b, held;
      a = $urandom;
      b = $urandom;
      start_txn(a, b, 3'b010, 1'b0);
      held = a + b;
      checks++; if (r_y !== held) begin failures++; $display("FAIL bp_y got=%h required=%h", r_y, held); end
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_a     = $urandom;
         in_b     = $urandom;
         in_op    = 3'b001;
         @(posedge clk);
         #1;
         checks++; if (out_y !== held) begin failures++; $display("FAIL bp%0d_stable got=%h required=%h", i, out_y, held); end
         checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp%0d_ready got=%b required=0", i, in_ready); end
         checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp%0d_valid got=%b required=1", i, out_valid); end
      end
      in_valid = 1'b0;
      finish_txn();
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_idle_ready got=%b required=1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_single_resp got=%b required=0", out_valid); end
      @(posedge clk);
      #1;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL bp_no_accept busy=%b required=0", busy); end
   endtask

   task automatic test_back_to_back();
      int prev;
      logic [31:0] a, b;
      for (int i = 0; i < 5; i++) begin
         a = $urandom;
         b = $urandom;
         start_txn(a, b, 3'b110, 1'b1);
         checks++; if (r_y !== a - b) begin failures++; $display("FAIL b2b%0d_y got=%h required=%h", i, r_y, a - b); end
         if (i > 0) begin
            checks++; if (acc_cyc - prev != 3) begin failures++; $display("FAIL b2b%0d_spacing got=%0d required=3", i, acc_cyc - prev); end
         end
         prev = acc_cyc;
         finish_txn();
      end
   endtask

   task automatic test_reset_abandon();
`ifdef ULA_SEQ_MUL_EN
      accept_req(32'h1234_5678, 32'h9ABC_DEF1, 3'b011, 1'b0);
      repeat (9) @(posedge clk);
`else
      accept_req(32'h1234_5678, 32'h9ABC_DEF1, 3'b010, 1'b0);
      @(posedge clk);
`endif
      #1;
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL abandon_busy_before got=%b required=1", busy); end
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abandon_busy got=%b required=0", busy); end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL abandon_valid got=%b required=0", out_valid); end
      checks++; if (out_y !== 32'h0) begin failures++; $display("FAIL abandon_y got=%h required=0", out_y); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL abandon_ready got=%b required=1", in_ready); end
      start_txn(32'd1, 32'd1, 3'b010, 1'b0);
      checks++; if (r_y !== 32'd2) begin failures++; $display("FAIL abandon_add_y got=%h required=2", r_y); end
      finish_txn();
   endtask

   initial begin
      test_reset();
      test_directed();
`ifdef ULA_SEQ_MUL_EN
      test_mul();
`else
      test_unsupported();
`endif
      test_random();
      test_backpressure();
      test_back_to_back();
      test_reset_abandon();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ula_seq.md
# ula_seq

Sequencing controller that owns one 32-bit ULA (AND/OR/ADD/SUB/SLT datapath, 3-bit function code) and exposes it to a client over a valid/ready request/response interface. Single-step operations issue one ULA cycle. A multi-cycle 32×32 multiply (low 32 bits) is built from 32 shift-and-add iterations on the same ULA. Sits between the instruction-level control and the shared ULA instance, adding registered results, a zero flag and back-pressure.

## Interface
Parameters:
- none; datapath width fixed at 32, iteration count fixed at 32.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; sampled on rising edge of clk.
- in_valid  in  1  request present.
- in_ready  out  1  controller can accept a request; high only in IDLE.
- in_a  in  32  operand A.
- in_b  in  32  operand B.
- in_op  in  3  operation code (see Operation).
- out_valid  out  1  result held on out_y/out_zero/out_err.
- out_ready  in  1  client accepts result.
- out_y  out  32  result.
- out_zero  out  1  high iff out_y == 0.
- out_err  out  1  request used an unsupported opcode.
- busy  out  1  high in every state except IDLE.

## Operation
- Internal ULA instance; function input driven by the controller.
- Opcodes 000 AND, 001 OR, 010 ADD, 100 AND-NOT-B, 101 OR-NOT-B, 110 SUB, 111 SLT go straight to the ULA as its function code. SLT is sign of a−b; overflow is ignored.
- Opcode 011 is MUL: low 32 bits of a×b. Signed and unsigned give identical low bits.
- All arithmetic is mod 2^32; carries are discarded.
- States:
  - IDLE: in_ready=1. On in_valid, capture a, b and op. Go to MUL if op==011 and the multiply is compiled in, else to EXEC.
  - EXEC: ULA(a_q, b_q, op_q) is registered into y_q, with zero_q = (ULA result==0) and err_q=0. Go to DONE.
  - MUL: registers acc (starts 0), mcand (starts a), mplr (starts b) and a 5-bit counter cnt (starts 0). Each cycle:
    - if mplr[0], acc ← ULA(acc, mcand, 010), else acc is held.
    - mcand ← mcand<<1; mplr ← mplr>>1; cnt ← cnt+1.
    - When cnt==31, the final update is written to y_q, zero_q is set from it, and the state goes to DONE.
    - No early termination: always 32 iterations.
  - DONE: out_valid=1 and outputs are stable. On out_ready go to IDLE. No new request is accepted in DONE.
- The ULA function input is 010 during MUL and op_q during EXEC. Its value in IDLE/DONE is irrelevant and is not observed.
- Reset: state←IDLE, out_y=0, out_zero=0, out_err=0, out_valid=0, busy=0, in_ready=1. An operation in EXEC, MUL or DONE is abandoned without producing a result.

## Timing
- Request handshake: in_valid & in_ready at edge E0.
- Single-step op: result registered at E1; out_valid high during the cycle after E1. Latency is 1 cycle.
- MUL: iterations occur at E1..E32; out_valid high after E32. Latency is 32 cycles.
- Response handshake: out_valid & out_ready at edge Ed. in_ready is high the cycle after Ed, so the minimum request spacing is 3 cycles for single-step ops.
- out_ready high before out_valid has no effect. A result is never dropped or duplicated.
- in_valid while busy is ignored. The requester must hold in_a/in_b/in_op until in_ready.
- reset takes priority over any handshake on the same edge.

## Configuration
- ULA_SEQ_MUL_EN defined: opcode 011 performs MUL as above.
- ULA_SEQ_MUL_EN undefined:
  - MUL state, acc/mcand/mplr/cnt are not built.
  - Opcode 011 goes to EXEC but the ULA is not used; result y=0, zero=1, err=1, latency 1 cycle.
  - All other opcodes are unchanged. out_err is always 0 when the macro is defined.

## Test plan
- Reset, then ADD a=0x00000005 b=0x00000003 with out_ready=1 → out_valid one cycle after accept, out_y=0x00000008, zero=0, err=0; in_ready high the cycle after response.
- SUB a=0x00000007 b=0x00000007 → out_y=0, zero=1. SLT a=0xFFFFFFFF b=0x00000001 → out_y=1. AND a=0xF0F0F0F0 b=0x0FF00FF0 → out_y=0x00F000F0.
- MUL (macro defined) a=0x00001234 b=0x00005678 → out_valid exactly 32 cycles after accept, out_y=0x06260060. Also a=0xFFFFFFFF b=0xFFFFFFFF → out_y=0x00000001, and a=0 b=0x12345678 → out_y=0, zero=1.
- Back-pressure: out_ready=0 for 5 cycles after out_valid → out_y held stable, in_ready=0, and an in_valid pulse during this window is not accepted. Then raise out_ready → single response, IDLE.
- Reset asserted at MUL iteration 10 → next cycle busy=0, out_valid=0, out_y=0, in_ready=1. A following ADD 1+1 returns 2.
- Macro undefined: opcode 011 a=3 b=4 → 1-cycle latency, out_y=0, zero=1, err=1. Subsequent OR a=0x1 b=0x2 → out_y=0x3, err=0.
